// File: rtl/trap_seq_pkg.sv
// Shared CSR definitions for the trap sequencer: CSR layouts, privilege and
// state encodings, CSR addresses and the interrupt priority table.
package trap_seq_pkg;

   typedef logic [5:0]  exc_code_t;
   typedef logic [63:0] csr_ip_t;

   typedef struct packed {
      logic [50:0] rsvd_hi;
      logic [1:0]  mpp;
      logic [2:0]  rsvd_mid;
      logic        mpie;
      logic [2:0]  rsvd_lo2;
      logic        mie;
      logic [2:0]  rsvd_lo;
   } csr_status_t;

   typedef enum logic [1:0] {
      TVEC_DIRECT   = 2'd0,
      TVEC_VECTORED = 2'd1
   } tvec_mode_t;

   typedef struct packed {
      logic [61:0] base;
      tvec_mode_t  mode;
   } csr_tvec_t;

   typedef struct packed {
      logic        irq;
      logic [62:0] code;
   } csr_cause_t;

   typedef enum logic [1:0] {
      PRIV_U = 2'b00,
      PRIV_S = 2'b01,
      PRIV_M = 2'b11
   } priv_t;

   typedef enum logic [1:0] {
      CSR_OP_READ  = 2'd0,
      CSR_OP_WRITE = 2'd1,
      CSR_OP_SET   = 2'd2,
      CSR_OP_CLEAR = 2'd3
   } csr_op_t;

   typedef enum logic [2:0] {
      IDLE,
      W_EPC,
      W_CAUSE,
      W_TVAL,
      W_STATUS,
      M_STATUS,
      REDIRECT
   } state_t;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;

   // Highest priority first: MEI, MSI, MTI, SEI, SSI, STI.
   localparam int unsigned INT_PRIO_N = 6;
   localparam exc_code_t INT_PRIO [INT_PRIO_N] = '{6'd11, 6'd3, 6'd7, 6'd9, 6'd1, 6'd5};

endpackage

// File: rtl/trap_seq_if.sv
// Sequential CSR write port driven by the trap sequencer into the CSR file.
interface csr_bus;
   import trap_seq_pkg::*;

   logic        csr_en;
   csr_op_t     op;
   logic [11:0] addr;
   logic [63:0] wdata;
   logic        trap_ill;

   modport master (output csr_en, op, addr, wdata, input trap_ill);
   modport slave  (input csr_en, op, addr, wdata, output trap_ill);

endinterface

// File: rtl/trap_seq_prio.sv
// Fixed-priority interrupt encoder: pending vector -> valid + cause code.
module int_prio_enc
   import trap_seq_pkg::*;
(
   input  csr_ip_t   pend,
   output logic      valid,
   output exc_code_t code
);

   // Walk lowest priority first so the highest pending entry is the last writer.
   always_comb begin
      valid = 1'b0;
      code  = '0;
      for (int unsigned i = 0; i < INT_PRIO_N; i++) begin
         if (pend[INT_PRIO[INT_PRIO_N - 1 - i]]) begin
            valid = 1'b1;
            code  = INT_PRIO[INT_PRIO_N - 1 - i];
         end
      end
   end

   logic unused_pend;
   assign unused_pend = ^{pend[63:12], pend[10], pend[8], pend[6], pend[4], pend[2], pend[0]};

endmodule

// File: rtl/trap_seq.sv
// Machine-mode trap/MRET sequencer: accepts one exception, interrupt or MRET,
// writes the trap CSRs one per cycle, then issues a single fetch redirect.
module trap_seq
   import trap_seq_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        exc_valid,
   input  exc_code_t   exc_code,
   input  logic [63:0] exc_tval,
   input  logic [63:0] exc_pc,
   input  logic        mret_valid,
   input  logic        int_pending,
   input  csr_status_t mstatus_q,
   input  csr_tvec_t   mtvec_q,
   input  csr_ip_t     mie_q,
   input  csr_ip_t     mip_q,
   input  logic [63:0] mepc_q,
   csr_bus.master      csr,
   output logic        busy,
   output logic        redirect_valid,
   output logic [63:0] redirect_pc,
   output logic [1:0]  priv
);

   state_t      state_q, state_d;
   priv_t       priv_q, priv_d;
   csr_cause_t  cause_q, cause_d;
   logic [63:0] tval_q, tval_d;
   logic [63:0] pc_q, pc_d;
   logic        mret_q, mret_d;

   csr_ip_t     int_vec;
   logic        int_valid;
   exc_code_t   int_code;
   logic        int_take;
   csr_status_t status_trap;
   csr_status_t status_mret;
   logic [63:0] trap_target;

   assign int_vec = mip_q & mie_q;

   int_prio_enc u_prio (
      .pend  (int_vec),
      .valid (int_valid),
      .code  (int_code)
   );

   // Interrupts below M are always enabled; in M they need mstatus.mie.
   assign int_take = int_valid && int_pending && ((priv_q != PRIV_M) || mstatus_q.mie);

   always_comb begin
      status_trap      = mstatus_q;
      status_trap.mpie = mstatus_q.mie;
      status_trap.mie  = 1'b0;
      status_trap.mpp  = priv_q;

      status_mret      = mstatus_q;
      status_mret.mie  = mstatus_q.mpie;
      status_mret.mpie = 1'b1;
      status_mret.mpp  = PRIV_U;

      trap_target = {mtvec_q.base, 2'b00};
      if (mtvec_q.mode == TVEC_VECTORED && cause_q.irq)
         trap_target = trap_target + ({1'b0, cause_q.code} << 2);
   end

   always_comb begin
      state_d        = state_q;
      priv_d         = priv_q;
      cause_d        = cause_q;
      tval_d         = tval_q;
      pc_d           = pc_q;
      mret_d         = mret_q;
      csr.csr_en     = 1'b0;
      csr.op         = CSR_OP_WRITE;
      csr.addr       = '0;
      csr.wdata      = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;

      unique case (state_q)
         IDLE: begin
            if (exc_valid) begin
               cause_d.irq  = 1'b0;
               cause_d.code = 63'(exc_code);
               tval_d       = exc_tval;
               pc_d         = exc_pc;
               mret_d       = 1'b0;
               state_d      = W_EPC;
            end else if (int_take) begin
               cause_d.irq  = 1'b1;
               cause_d.code = 63'(int_code);
               tval_d       = '0;
               pc_d         = exc_pc;
               mret_d       = 1'b0;
               state_d      = W_EPC;
            end else if (mret_valid) begin
               mret_d  = 1'b1;
               state_d = M_STATUS;
            end
         end
         W_EPC: begin
            csr.csr_en = 1'b1;
            csr.addr   = CSR_MEPC;
            csr.wdata  = {pc_q[63:1], 1'b0};
            state_d    = W_CAUSE;
         end
         W_CAUSE: begin
            csr.csr_en = 1'b1;
            csr.addr   = CSR_MCAUSE;
            csr.wdata  = cause_q;
            state_d    = W_TVAL;
         end
         W_TVAL: begin
            csr.csr_en = 1'b1;
            csr.addr   = CSR_MTVAL;
            csr.wdata  = tval_q;
            state_d    = W_STATUS;
         end
         W_STATUS: begin
            csr.csr_en = 1'b1;
            csr.addr   = CSR_MSTATUS;
            csr.wdata  = status_trap;
            priv_d     = PRIV_M;
            state_d    = REDIRECT;
         end
         M_STATUS: begin
            csr.csr_en = 1'b1;
            csr.addr   = CSR_MSTATUS;
            csr.wdata  = status_mret;
            priv_d     = priv_t'(mstatus_q.mpp);
            state_d    = REDIRECT;
         end
         REDIRECT: begin
            redirect_valid = 1'b1;
            redirect_pc    = mret_q ? mepc_q : trap_target;
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         priv_q  <= PRIV_M;
         cause_q <= '0;
         tval_q  <= '0;
         pc_q    <= '0;
         mret_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         priv_q  <= priv_d;
         cause_q <= cause_d;
         tval_q  <= tval_d;
         pc_q    <= pc_d;
         mret_q  <= mret_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign priv = priv_q;

   logic unused_trap_ill;
   assign unused_trap_ill = csr.trap_ill;

endmodule
